// File: rtl/wave_seq_ctrl.sv
// Segment sequencer for wave_gen. Plays a programmable segment table and ramps
// gain one LSB per clock into and out of every segment.
`timescale 1ns/1ps
module wave_seq_ctrl #(
   parameter  int DEPTH   = 1024,
   parameter  int NUM_SEG = 8,
   parameter  int DWELL_W = 16,
   localparam int PW      = $clog2(DEPTH),
   localparam int AW      = $clog2(NUM_SEG)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cfg_we,
   input  logic [AW-1:0]        i_cfg_addr,
   input  logic [2:0]           i_cfg_wave,
   input  logic [PW-1:0]        i_cfg_step,
   input  logic [2:0]           i_cfg_duty,
   input  logic signed [3:0]    i_cfg_gain,
   input  logic [DWELL_W-1:0]   i_cfg_dwell,
   input  logic [AW:0]          i_num_seg,
   input  logic                 i_loop,
   input  logic                 i_start,
   input  logic                 i_stop,
   output logic [2:0]           o_sel_wave,
   output logic [PW-1:0]        o_wave_phase_step,
   output logic [2:0]           o_sel_duty_cycle,
   output logic signed [3:0]    o_gain,
   output logic                 o_busy,
   output logic [AW-1:0]        o_seg_idx,
   output logic                 o_seg_done,
   output logic                 o_done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FADE_IN,
      ST_HOLD,
      ST_FADE_OUT
   } state_e;

   typedef struct packed {
      logic [2:0]         wave;
      logic [PW-1:0]      step;
      logic [2:0]         duty;
      logic signed [3:0]  gain;
      logic [DWELL_W-1:0] dwell;
   } seg_t;

   localparam logic [2:0]  WAVE_ZERO   = 3'd5;
   localparam logic [AW:0] NUM_SEG_MAX = (AW+1)'(NUM_SEG);

   seg_t                tbl_q [NUM_SEG];

   state_e              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [AW:0]         num_seg_q, num_seg_d;
   logic                loop_q, loop_d;
   logic                stop_q, stop_d;
   logic signed [3:0]   target_q, target_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic signed [3:0]   gain_q, gain_d;
   logic [2:0]          wave_q, wave_d;
   logic [PW-1:0]       step_q, step_d;
   logic [2:0]          duty_q, duty_d;
   logic                seg_done_q, seg_done_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                start_ok;
   logic                last_seg;
   logic                stop_any;
   logic signed [3:0]   fade_in_gain;
   logic signed [3:0]   fade_out_gain;
   seg_t                cur_entry;

   // Single-LSB move toward a target; never passes it, so gain stays in range.
   function automatic logic signed [3:0] step_toward(input logic signed [3:0] cur,
                                                     input logic signed [3:0] tgt);
      logic signed [3:0] res;
      res = cur;
      if (cur < tgt) begin
         res = cur + 4'sd1;
      end else if (cur > tgt) begin
         res = cur - 4'sd1;
      end
      return res;
   endfunction

   assign start_ok      = (i_num_seg != '0) && (i_num_seg <= NUM_SEG_MAX);
   assign last_seg      = ({1'b0, idx_q} == (num_seg_q - (AW+1)'(1)));
   assign stop_any      = stop_q | i_stop;
   assign fade_in_gain  = step_toward(gain_q, target_q);
   assign fade_out_gain = step_toward(gain_q, 4'sd0);
   assign cur_entry     = tbl_q[idx_q];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_SEG; i++) begin
            tbl_q[i] <= '0;
         end
      end else if (i_cfg_we) begin
         tbl_q[i_cfg_addr] <= '{wave:  i_cfg_wave,
                                step:  i_cfg_step,
                                duty:  i_cfg_duty,
                                gain:  i_cfg_gain,
                                dwell: i_cfg_dwell};
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      num_seg_d  = num_seg_q;
      loop_d     = loop_q;
      stop_d     = stop_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      gain_d     = gain_q;
      wave_d     = wave_q;
      step_d     = step_q;
      duty_d     = duty_q;
      seg_done_d = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start && start_ok) begin
               state_d   = ST_LOAD;
               idx_d     = '0;
               num_seg_d = i_num_seg;
               loop_d    = i_loop;
               stop_d    = 1'b0;
            end
         end

         ST_LOAD: begin
            wave_d   = cur_entry.wave;
            step_d   = cur_entry.step;
            duty_d   = cur_entry.duty;
            target_d = cur_entry.gain;
            cnt_d    = cur_entry.dwell;
            if (i_stop) begin
               stop_d  = 1'b1;
               state_d = ST_FADE_OUT;
            end else if (cur_entry.gain == 4'sd0) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_FADE_IN;
            end
         end

         ST_FADE_IN: begin
            if (i_stop) begin
               stop_d  = 1'b1;
               state_d = ST_FADE_OUT;
            end else begin
               gain_d = fade_in_gain;
               if (fade_in_gain == target_q) begin
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (i_stop) begin
               stop_d  = 1'b1;
               state_d = ST_FADE_OUT;
            end else if (cnt_q == '0) begin
               state_d = ST_FADE_OUT;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end

         ST_FADE_OUT: begin
            stop_d = stop_any;
            gain_d = fade_out_gain;
            // Segment boundary: the only place the sequence advances or ends.
            if (fade_out_gain == 4'sd0) begin
               if (stop_any || (last_seg && !loop_q)) begin
                  seg_done_d = !stop_any;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
                  idx_d      = '0;
                  stop_d     = 1'b0;
                  wave_d     = WAVE_ZERO;
                  step_d     = '0;
                  duty_d     = '0;
               end else begin
                  seg_done_d = 1'b1;
                  state_d    = ST_LOAD;
                  idx_d      = last_seg ? '0 : idx_q + AW'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         num_seg_q  <= '0;
         loop_q     <= 1'b0;
         stop_q     <= 1'b0;
         target_q   <= '0;
         cnt_q      <= '0;
         gain_q     <= '0;
         wave_q     <= WAVE_ZERO;
         step_q     <= '0;
         duty_q     <= '0;
         seg_done_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         num_seg_q  <= num_seg_d;
         loop_q     <= loop_d;
         stop_q     <= stop_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         gain_q     <= gain_d;
         wave_q     <= wave_d;
         step_q     <= step_d;
         duty_q     <= duty_d;
         seg_done_q <= seg_done_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign o_sel_wave        = wave_q;
   assign o_wave_phase_step = step_q;
   assign o_sel_duty_cycle  = duty_q;
   assign o_gain            = gain_q;
   assign o_busy            = busy_q;
   assign o_seg_idx         = idx_q;
   assign o_seg_done        = seg_done_q;
   assign o_done            = done_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: per-cycle expected output words are
// queued as stimulus is planned and popped one per clock.
`timescale 1ns/1ps
module tb_wave_seq_ctrl;

   localparam int PW      = 10;
   localparam int AW      = 3;
   localparam int DWELL_W = 16;

   logic                i_clk;
   logic                i_rst_n;
   logic                i_cfg_we;
   logic [AW-1:0]       i_cfg_addr;
   logic [2:0]          i_cfg_wave;
   logic [PW-1:0]       i_cfg_step;
   logic [2:0]          i_cfg_duty;
   logic signed [3:0]   i_cfg_gain;
   logic [DWELL_W-1:0]  i_cfg_dwell;
   logic [AW:0]         i_num_seg;
   logic                i_loop;
   logic                i_start;
   logic                i_stop;
   logic [2:0]          o_sel_wave;
   logic [PW-1:0]       o_wave_phase_step;
   logic [2:0]          o_sel_duty_cycle;
   logic signed [3:0]   o_gain;
   logic                o_busy;
   logic [AW-1:0]       o_seg_idx;
   logic                o_seg_done;
   logic                o_done;

   typedef struct packed {
      logic [2:0]        wave;
      logic [PW-1:0]     step;
      logic [2:0]        duty;
      logic signed [3:0] gain;
      logic [AW-1:0]     idx;
      logic              segDone;
      logic              done;
      logic              busy;
   } exp_t;

   localparam exp_t IDLE_EXP  = '{wave: 3'd5, step: 10'd0, duty: 3'd0, gain: 4'sd0,
                                  idx: 3'd0, segDone: 1'b0, done: 1'b0, busy: 1'b0};
   localparam exp_t START_EXP = '{wave: 3'd5, step: 10'd0, duty: 3'd0, gain: 4'sd0,
                                  idx: 3'd0, segDone: 1'b0, done: 1'b0, busy: 1'b1};

   exp_t sb[$];
   exp_t obs;
   int   vectors;
   int   miscompares;

   assign obs = {o_sel_wave, o_wave_phase_step, o_sel_duty_cycle, o_gain,
                 o_seg_idx, o_seg_done, o_done, o_busy};

   wave_seq_ctrl #(.DEPTH(1024), .NUM_SEG(8), .DWELL_W(16)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_cfg_we          (i_cfg_we),
      .i_cfg_addr        (i_cfg_addr),
      .i_cfg_wave        (i_cfg_wave),
      .i_cfg_step        (i_cfg_step),
      .i_cfg_duty        (i_cfg_duty),
      .i_cfg_gain        (i_cfg_gain),
      .i_cfg_dwell       (i_cfg_dwell),
      .i_num_seg         (i_num_seg),
      .i_loop            (i_loop),
      .i_start           (i_start),
      .i_stop            (i_stop),
      .o_sel_wave        (o_sel_wave),
      .o_wave_phase_step (o_wave_phase_step),
      .o_sel_duty_cycle  (o_sel_duty_cycle),
      .o_gain            (o_gain),
      .o_busy            (o_busy),
      .o_seg_idx         (o_seg_idx),
      .o_seg_done        (o_seg_done),
      .o_done            (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic set_cfg(input logic we, input int addr, input int wave, input int step,
                          input int duty, input int gain, input int dwell);
      i_cfg_we    = we;
      i_cfg_addr  = AW'(addr);
      i_cfg_wave  = 3'(wave);
      i_cfg_step  = PW'(step);
      i_cfg_duty  = 3'(duty);
      i_cfg_gain  = 4'(gain);
      i_cfg_dwell = DWELL_W'(dwell);
   endtask

   task automatic cfg_write(input int addr, input int wave, input int step,
                            input int duty, input int gain, input int dwell);
      set_cfg(1'b1, addr, wave, step, duty, gain, dwell);
      @(posedge i_clk); #1;
      i_cfg_we = 1'b0;
   endtask

   // Expected samples from the LOAD edge through the segment-end edge.
   task automatic push_seg(input int w, input int s, input int d, input int g, input int dw,
                           input int idx, input int nextIdx, input bit last);
      exp_t e;
      int   mag;
      int   sgn;
      mag = (g < 0) ? -g : g;
      sgn = (g < 0) ? -1 : 1;
      e = '{wave: 3'(w), step: PW'(s), duty: 3'(d), gain: 4'sd0, idx: AW'(idx),
            segDone: 1'b0, done: 1'b0, busy: 1'b1};
      sb.push_back(e);
      for (int k = 1; k <= mag; k++) begin
         e.gain = 4'(sgn * k);
         sb.push_back(e);
      end
      for (int k = 0; k <= dw; k++) sb.push_back(e);
      for (int k = mag - 1; k > 0; k--) begin
         e.gain = 4'(sgn * k);
         sb.push_back(e);
      end
      e.gain    = 4'sd0;
      e.segDone = 1'b1;
      e.idx     = AW'(nextIdx);
      if (last) begin
         e         = IDLE_EXP;
         e.segDone = 1'b1;
         e.done    = 1'b1;
      end
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t want;
      int   n;
      repeat (2) @(posedge i_clk);
      #1;
      vectors++;
      if (obs !== IDLE_EXP) begin
         miscompares++;
         $display("[TB] FAIL reset_values: actual %h required %h", obs, IDLE_EXP);
      end
      i_rst_n   = 1'b1;
      i_num_seg = 4'd1;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      push_seg(0, 0, 0, 0, 0, 0, 0, 1'b1);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL reset_table c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_single();
      exp_t want;
      int   n;
      cfg_write(0, 0, 4, 1, 3, 2);
      i_num_seg = 4'd1;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      push_seg(0, 4, 1, 3, 2, 0, 0, 1'b1);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL single c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_loop();
      exp_t want;
      int   n;
      int   stopAt;
      cfg_write(0, 1, 7, 3, -2, 0);
      cfg_write(1, 2, 9, 4, 1, 1);
      i_num_seg = 4'd2;
      i_loop    = 1'b1;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      push_seg(1, 7, 3, -2, 0, 0, 1, 1'b0);
      push_seg(2, 9, 4, 1, 1, 1, 0, 1'b0);
      push_seg(1, 7, 3, -2, 0, 0, 1, 1'b0);
      // Stop lands in segment 1's LOAD on the second pass.
      stopAt = sb.size() - 1;
      want = '{wave: 3'd2, step: 10'd9, duty: 3'd4, gain: 4'sd0, idx: 3'd1,
               segDone: 1'b0, done: 1'b0, busy: 1'b1};
      sb.push_back(want);
      want = IDLE_EXP;
      want.done = 1'b1;
      sb.push_back(want);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         i_stop  = (c == stopAt);
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL loop c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_stop();
      exp_t want;
      exp_t e;
      int   n;
      cfg_write(0, 3, 100, 5, 5, 10);
      i_num_seg = 4'd1;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      e = '{wave: 3'd3, step: 10'd100, duty: 3'd5, gain: 4'sd0, idx: 3'd0,
            segDone: 1'b0, done: 1'b0, busy: 1'b1};
      sb.push_back(e);
      for (int k = 1; k <= 5; k++) begin
         e.gain = 4'(k);
         sb.push_back(e);
      end
      sb.push_back(e);
      sb.push_back(e);
      for (int k = 4; k >= 1; k--) begin
         e.gain = 4'(k);
         sb.push_back(e);
      end
      e = IDLE_EXP;
      e.done = 1'b1;
      sb.push_back(e);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = (c == 7);
         i_stop  = (c == 7);
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL stop_hold c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_zero_gain();
      exp_t want;
      int   n;
      cfg_write(0, 4, 33, 6, 0, 3);
      i_num_seg = 4'd1;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      push_seg(4, 33, 6, 0, 3, 0, 0, 1'b1);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL zero_gain c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t want;
      int   n;
      int   wr2;
      cfg_write(0, 1, 10, 1, 2, 3);
      cfg_write(1, 2, 20, 2, 1, 0);
      cfg_write(2, 4, 40, 3, 1, 0);
      i_num_seg = 4'd3;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      push_seg(1, 10, 1, 2, 3, 0, 1, 1'b0);
      push_seg(6, 300, 7, -1, 1, 1, 2, 1'b0);
      wr2 = sb.size() - 1;
      push_seg(4, 40, 3, 1, 0, 2, 0, 1'b1);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         if (c == 4) set_cfg(1'b1, 1, 6, 300, 7, -1, 1);
         else if (c == wr2) set_cfg(1'b1, 2, 7, 500, 6, 3, 5);
         else i_cfg_we = 1'b0;
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL cfg_write c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   task automatic test_reset_midrun();
      exp_t want;
      exp_t e;
      int   n;
      cfg_write(0, 3, 50, 2, 7, 4);
      i_num_seg = 4'd1;
      i_loop    = 1'b0;
      i_start   = 1'b1;
      sb.push_back(START_EXP);
      e = '{wave: 3'd3, step: 10'd50, duty: 3'd2, gain: 4'sd0, idx: 3'd0,
            segDone: 1'b0, done: 1'b0, busy: 1'b1};
      sb.push_back(e);
      e.gain = 4'sd1;
      sb.push_back(e);
      e.gain = 4'sd2;
      sb.push_back(e);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         i_start = 1'b0;
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL fade_in c%0d: actual %h required %h", c, obs, want);
         end
      end
      #2 i_rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== IDLE_EXP) begin
         miscompares++;
         $display("[TB] FAIL async_reset: actual %h required %h", obs, IDLE_EXP);
      end
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      // Rejected counts (0, 9), then a full-length run over the cleared table.
      i_num_seg = 4'd0;
      i_start   = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back(IDLE_EXP);
      sb.push_back(START_EXP);
      for (int s = 0; s < 8; s++) push_seg(0, 0, 0, 0, 0, s, s + 1, s == 7);
      sb.push_back(IDLE_EXP);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         @(posedge i_clk); #1;
         case (c)
            0: i_num_seg = 4'd9;
            1: i_start = 1'b0;
            2: begin
               i_start   = 1'b1;
               i_num_seg = 4'd8;
            end
            default: i_start = 1'b0;
         endcase
         want = sb.pop_front();
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("[TB] FAIL post_reset c%0d: actual %h required %h", c, obs, want);
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, %0d vectors applied", vectors);
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      i_rst_n     = 1'b0;
      i_num_seg   = '0;
      i_loop      = 1'b0;
      i_start     = 1'b0;
      i_stop      = 1'b0;
      set_cfg(1'b0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_single();
      test_loop();
      test_stop();
      test_zero_gain();
      test_back_to_back();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
